// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os16
// Description : 8N1 UART receiver, 16x oversampling with 3-sample majority vote
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os16 #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int OS     = 16
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       Rx,
    input  logic       Rx_en,
    input  logic       ready_clr,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       Rx_busy
);
    localparam int C_DIV = CLK_HZ / (BAUD * OS);
    localparam int C_TW  = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_TW-1:0] C_TICK_LAST = C_TW'(C_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q;
    logic            rx_meta_q;
    logic            rxs_q;
    logic            rxs_prev_q;
    logic [C_TW-1:0] tick_cnt_q;
    logic [3:0]      os_cnt_q;
    logic [1:0]      samp_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            ready_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic            w_tick;
    logic [3:0]      w_os_next;
    logic            w_vote;
    logic            w_fall;

    assign w_tick    = (tick_cnt_q == C_TICK_LAST);
    assign w_os_next = os_cnt_q + 4'd1;
    assign w_fall    = rxs_prev_q & ~rxs_q;
    // Samples land on the ticks that take os_cnt to 7 and 8; the live rxs is the third vote.
    assign w_vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            tick_cnt_q  <= '0;
            os_cnt_q    <= 4'd0;
            samp_q      <= 2'b11;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q  <= Rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;

            if (ready_clr) begin
                ready_q     <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            if (state_q == S_IDLE) begin
                if (Rx_en && w_fall) begin
                    state_q    <= S_START;
                    tick_cnt_q <= '0;
                    os_cnt_q   <= 4'd0;
                end
            end else if (!Rx_en) begin
                state_q <= S_IDLE;
            end else if (state_q == S_BREAK) begin
                if (rxs_q) begin
                    state_q <= S_IDLE;
                end
            end else begin
                tick_cnt_q <= w_tick ? '0 : tick_cnt_q + 1'b1;
                if (w_tick) begin
                    os_cnt_q <= w_os_next;
                    if (w_os_next == 4'd7 || w_os_next == 4'd8) begin
                        samp_q <= {samp_q[0], rxs_q};
                    end
                    if (w_os_next == 4'd9) begin
                        case (state_q)
                            S_START: begin
                                if (w_vote) begin
                                    state_q <= S_IDLE;
                                end else begin
                                    state_q   <= S_DATA;
                                    bit_idx_q <= 3'd0;
                                end
                            end
                            S_DATA: begin
                                shift_q   <= {w_vote, shift_q[7:1]};
                                bit_idx_q <= bit_idx_q + 3'd1;
                                if (bit_idx_q == 3'd7) begin
                                    state_q <= S_STOP;
                                end
                            end
                            S_STOP: begin
                                if (w_vote) begin
                                    state_q <= S_IDLE;
                                    // A same-cycle clear frees the holding register first.
                                    if (!ready_q || ready_clr) begin
                                        data_q  <= shift_q;
                                        ready_q <= 1'b1;
                                    end else begin
                                        overrun_q <= 1'b1;
                                    end
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= S_BREAK;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign data_out  = data_q;
    assign ready     = ready_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign Rx_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os16
// Description : directed self-checking bench for uart_rx_os16
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os16;
    localparam int C_BIT = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic       Rx;
    logic       Rx_en;
    logic       ready_clr;
    logic [7:0] data_out;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       Rx_busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt;
    logic got;
    logic busy_ok;
    logic saw_busy;
    logic [7:0] partial;
    logic [7:0] lb_bytes [4];

    always #10 clk = ~clk;

    uart_rx_os16 dut (
        .clk_50m   (clk),
        .rst       (rst),
        .Rx        (Rx),
        .Rx_en     (Rx_en),
        .ready_clr (ready_clr),
        .data_out  (data_out),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .Rx_busy   (Rx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_b);
        @(negedge clk);
        Rx = 1'b0;
        repeat (C_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (C_BIT) @(negedge clk);
        end
        Rx = stop_b;
        repeat (C_BIT) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ready_clr = 1'b1;
        @(negedge clk);
        ready_clr = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        Rx        = 1'b1;
        Rx_en     = 1'b1;
        ready_clr = 1'b0;
        lb_bytes  = '{8'h00, 8'hFF, 8'h01, 8'h80};
        repeat (4) @(negedge clk);
        check("rst_data", data_out, 8'h00);
        check("rst_ready", ready, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", Rx_busy, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // First frame: latency from the start edge and busy across the frame
        fork
            send_byte(8'h55, 1'b1);
            begin
                @(negedge clk);
                cnt = 0; got = 1'b0; busy_ok = 1'b1;
                while (!got && cnt < 5000) begin
                    @(negedge clk);
                    cnt++;
                    if (ready) got = 1'b1;
                    else if (cnt >= 3 && !Rx_busy) busy_ok = 1'b0;
                end
            end
        join
        check("lat_seen", got, 1'b1);
        check("lat_window", (cnt >= 4108 && cnt <= 4162), 1'b1);
        check("busy_frame", busy_ok, 1'b1);
        check("f55_data", data_out, 8'h55);
        check("f55_ferr", frame_err, 1'b0);
        pulse_clr();
        check("clr_ready", ready, 1'b0);
        check("clr_data", data_out, 8'h55);

        // Short low glitch is a false start
        @(negedge clk);
        Rx = 1'b0; saw_busy = 1'b0;
        repeat (150) begin @(negedge clk); if (Rx_busy) saw_busy = 1'b1; end
        Rx = 1'b1;
        repeat (600) begin @(negedge clk); if (Rx_busy) saw_busy = 1'b1; end
        check("glitch_busy_pulse", saw_busy, 1'b1);
        check("glitch_idle", Rx_busy, 1'b0);
        check("glitch_ready", ready, 1'b0);
        check("glitch_ferr", frame_err, 1'b0);
        check("glitch_data", data_out, 8'h55);

        // Stop bit low, line held low another bit time
        send_byte(8'hA5, 1'b0);
        repeat (C_BIT) @(negedge clk);
        check("brk_busy", Rx_busy, 1'b1);
        Rx = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_set", frame_err, 1'b1);
        check("ferr_ready", ready, 1'b0);
        check("ferr_data", data_out, 8'h55);
        check("ferr_idle", Rx_busy, 1'b0);
        send_byte(8'h3C, 1'b1);
        check("f3c_ready", ready, 1'b1);
        check("f3c_data", data_out, 8'h3C);
        pulse_clr();
        check("f3c_clr_ferr", frame_err, 1'b0);

        // Back-to-back frames without clearing
        send_byte(8'h12, 1'b1);
        check("b2b1_ready", ready, 1'b1);
        check("b2b1_data", data_out, 8'h12);
        check("b2b1_ovr", overrun, 1'b0);
        send_byte(8'h34, 1'b1);
        check("b2b2_ovr", overrun, 1'b1);
        check("b2b2_data", data_out, 8'h12);
        check("b2b2_ready", ready, 1'b1);
        pulse_clr();
        check("b2b_clr_ready", ready, 1'b0);
        check("b2b_clr_ovr", overrun, 1'b0);
        check("b2b_clr_ferr", frame_err, 1'b0);

        // Clear coincident with the stop vote (edge 4134 after the start negedge)
        send_byte(8'h99, 1'b1);
        check("f99_ready", ready, 1'b1);
        fork
            send_byte(8'h7E, 1'b1);
            begin
                @(negedge clk);
                repeat (4133) @(negedge clk);
                ready_clr = 1'b1;
                @(negedge clk);
                ready_clr = 1'b0;
            end
        join
        check("coinc_data", data_out, 8'h7E);
        check("coinc_ready", ready, 1'b1);
        check("coinc_ovr", overrun, 1'b0);

        // Reset in the middle of data bit 4
        partial = 8'hC3;
        @(negedge clk);
        Rx = 1'b0;
        repeat (C_BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            Rx = partial[i];
            repeat (C_BIT) @(negedge clk);
        end
        Rx = partial[4];
        repeat (C_BIT / 2) @(negedge clk);
        check("mid_busy", Rx_busy, 1'b1);
        rst = 1'b1; Rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_data", data_out, 8'h00);
        check("mrst_ready", ready, 1'b0);
        check("mrst_ferr", frame_err, 1'b0);
        check("mrst_ovr", overrun, 1'b0);
        check("mrst_busy", Rx_busy, 1'b0);
        repeat (C_BIT) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        check("post_rst_data", data_out, 8'h5A);
        check("post_rst_ready", ready, 1'b1);
        pulse_clr();

        // Loopback-style byte sweep
        for (int k = 0; k < 4; k++) begin
            send_byte(lb_bytes[k], 1'b1);
            check("lb_data", data_out, lb_bytes[k]);
            check("lb_ready", ready, 1'b1);
            check("lb_ferr", frame_err, 1'b0);
            check("lb_ovr", overrun, 1'b0);
            pulse_clr();
            check("lb_clr", ready, 1'b0);
        end

        // Enable drop mid-frame aborts to idle
        @(negedge clk);
        Rx = 1'b0;
        repeat (1000) @(negedge clk);
        check("en_busy", Rx_busy, 1'b1);
        Rx_en = 1'b0;
        @(negedge clk);
        check("en_abort_busy", Rx_busy, 1'b0);
        check("en_abort_ready", ready, 1'b0);
        check("en_abort_ferr", frame_err, 1'b0);
        Rx = 1'b1;
        repeat (20) @(negedge clk);
        Rx_en = 1'b1;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
Standalone UART receiver using 16x oversampling for the 50 MHz UART subsystem; the receive-side counterpart to the existing transmit path.
- Recovers 8N1 frames from the asynchronous Rx line using majority-vote mid-bit sampling.
- Presents each byte with the team's ready/ready_clr handshake.
- Flags framing errors and overruns. Used for external serial input and as the loopback checker for transmitter tests.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line baud rate
OS, 16, oversample ticks per bit (fixed 16; other values unsupported)
DIV, CLK_HZ/(BAUD*OS) (=27), clocks per oversample tick, integer-truncated

Ports:
clk_50m  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
Rx  input  1  asynchronous serial line, idle high
Rx_en  input  1  level enable; low holds receiver in IDLE
ready_clr  input  1  one-cycle pulse; clears ready, frame_err, overrun
data_out  output  8  last good received byte
ready  output  1  byte valid, held until ready_clr
frame_err  output  1  sticky: stop bit sampled 0
overrun  output  1  sticky: byte completed while ready was still 1
Rx_busy  output  1  high whenever state != IDLE

Behaviour:
Reset (rst=1 at a clk_50m edge):
- data_out=0x00, ready=0, frame_err=0, overrun=0, Rx_busy=0.
- State = IDLE; synchronizer flops = 1; counters = 0.
- Applies mid-frame: the partial byte is discarded and no flag is set.

Input path and timing:
- Rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Tick counter counts 0..DIV-1 and emits a 1-cycle tick at DIV-1. It is cleared on start detection so sampling phase aligns to the edge.
- Oversample counter os_cnt (4 bits) advances on each tick; one bit period = 16 ticks = 432 clocks at defaults.
- Bit value = majority of rxs at os_cnt 7, 8, 9, decided on the tick where os_cnt=9.

State machine:
- IDLE: Rx_busy=0. When Rx_en=1 and rxs falls 1->0, go to START and clear the tick and os counters.
- START: at the vote, start bit 1 is a false start: return to IDLE with no flags. Start bit 0: go to DATA with bit_idx=0.
- DATA: 8 bits, LSB first, one vote per 16 ticks, shifted into shift_reg. After bit_idx=7, go to STOP.
- STOP, stop vote=1: go to IDLE and run the completion rules.
- STOP, stop vote=0: set frame_err, leave data_out and ready unchanged, go to BREAK.
- BREAK: wait until rxs=1, then go to IDLE. No new start is detected before the line returns high.

Completion rules (apply in the same cycle as the stop vote):
- ready=0: data_out<=shift_reg, ready<=1.
- ready=1 and ready_clr=0: overrun<=1; byte dropped; data_out unchanged.
- ready_clr=1 in the same cycle: the clear applies first, so the new byte loads, ready stays 1, and no overrun is flagged.

Handshake and enable:
- ready_clr=1 (no completion that cycle): ready, frame_err and overrun go 0 on the next edge. data_out holds its value.
- Rx_en dropping to 0 in any non-IDLE state aborts to IDLE next cycle. No flags; outputs unchanged.

Latency:
- ready rises about 9.5 bit periods after the Rx falling edge: 2 synchronizer clocks + (9*16+9) ticks*DIV, within ±DIV clocks.
- Nominal at defaults: about 4135 clocks, 82.7 us.

Test Plan:
- Reset, Rx_en=1, drive 8N1 frame 0x55 at 115200 baud (8680 ns per bit) -> ready rises 4135±27 clocks after start edge; data_out=0x55; frame_err=0; Rx_busy high throughout the frame. Pulse ready_clr -> ready=0 next cycle, data_out stays 0x55.
- Rx low glitch of 3 us (under half a bit) from IDLE -> Rx_busy pulses, then returns to IDLE; ready, frame_err and data_out unchanged.
- Frame 0xA5 with stop bit driven 0, line held low 2 bit times then high -> frame_err=1, ready=0, data_out keeps prior value 0x55. Next valid frame 0x3C -> ready=1, data_out=0x3C.
- Back-to-back frames 0x12 then 0x34, no ready_clr -> after first, ready=1 and data_out=0x12; after second, overrun=1 and data_out stays 0x12. ready_clr clears all three flags.
- Assert ready_clr exactly on the stop-vote cycle of frame 0x7E while ready=1 -> data_out=0x7E, ready=1, overrun=0.
- Loopback against a transmitter, bytes 0x00..0xFF, ready_clr after each ready -> every byte matches, zero error flags. Separately, assert rst mid-frame at bit 4 -> all outputs 0, Rx_busy=0 next cycle, and the following full frame is received correctly.
